// File: rtl/ahbl_to_axi_bridge.sv
// ahbl_to_axi_bridge: AHB-Lite slave that turns every accepted beat into one single-beat AXI3 access
module ahbl_to_axi_bridge #(
    parameter int ID_WIDTH = 5,
    parameter int AXI_ID   = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [2:0]          HBURST,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [31:0]         HRDATA,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [31:0]         AWADDR,
    output logic [ID_WIDTH-1:0] AWID,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [31:0]         WDATA,
    output logic [3:0]          WSTRB,
    output logic                WLAST,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,
    input  logic [ID_WIDTH-1:0] BID,
    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [31:0]         ARADDR,
    output logic [ID_WIDTH-1:0] ARID,
    output logic [3:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    input  logic                RVALID,
    output logic                RREADY,
    input  logic [31:0]         RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic [ID_WIDTH-1:0] RID
);
    typedef enum logic [2:0] {IDLE, WR_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ERR1, ERR2} state_t;
    state_t state, state_nx;
    logic accept, bad, aw_done, w_done, unused;
    logic [3:0] strb;

    assign unused = ^{HBURST, HTRANS[0], BRESP[0], BID, RRESP[0], RLAST, RID};
    assign accept = HSEL & HREADY & HTRANS[1] & (state == IDLE || state == ERR2);
    assign bad = (HSIZE > 3'b010) | (HSIZE == 3'b001 & HADDR[0]) | (HSIZE == 3'b010 & |HADDR[1:0]);
    assign strb = HSIZE == 3'b000 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'b001 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // a valid that already handshook no longer holds up the exit from WR_REQ
    assign aw_done = ~AWVALID | AWREADY;
    assign w_done = ~WVALID | WREADY;

    assign HREADYOUT = state == IDLE || state == ERR2;
    assign HRESP = state == ERR1 || state == ERR2;
    assign BREADY = state == WR_RESP;
    assign ARVALID = state == RD_REQ;
    assign RREADY = state == RD_RESP;
    assign ARADDR = AWADDR;
    assign ARSIZE = AWSIZE;
    assign AWID = ID_WIDTH'(AXI_ID);
    assign ARID = ID_WIDTH'(AXI_ID);
    assign AWLEN = 4'd0;
    assign ARLEN = 4'd0;
    assign AWBURST = 2'b01;
    assign ARBURST = 2'b01;
    assign WLAST = 1'b1;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ERR2: state_nx = !accept ? IDLE : bad ? ERR1 : HWRITE ? WR_DATA : RD_REQ;
            WR_DATA:    state_nx = WR_REQ;
            WR_REQ:     if (aw_done & w_done) state_nx = WR_RESP;
            WR_RESP:    if (BVALID) state_nx = BRESP[1] ? ERR1 : IDLE;
            RD_REQ:     if (ARREADY) state_nx = RD_RESP;
            RD_RESP:    if (RVALID) state_nx = RRESP[1] ? ERR1 : IDLE;
            ERR1:       state_nx = ERR2;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= IDLE;
            AWADDR  <= 32'd0;
            AWSIZE  <= 3'd0;
            WSTRB   <= 4'd0;
            WDATA   <= 32'd0;
            HRDATA  <= 32'd0;
            AWVALID <= 1'b0;
            WVALID  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                AWADDR <= HADDR;
                AWSIZE <= HSIZE;
                WSTRB  <= strb;
            end
            if (state == WR_DATA) WDATA <= HWDATA;
            AWVALID <= state == WR_DATA | (AWVALID & ~AWREADY);
            WVALID  <= state == WR_DATA | (WVALID & ~WREADY);
            if (state == RD_RESP && RVALID) HRDATA <= RDATA;
        end
    end
endmodule

// File: tb/tb_ahbl_to_axi_bridge.sv
// tb_ahbl_to_axi_bridge: randomized bench checking the bridge against a transfer-level model
`timescale 1ns/1ps
module tb_ahbl_to_axi_bridge;
    localparam int IDW = 5;
    localparam int AXI_ID = 3;

    logic HCLK = 0, HRESET = 1;
    logic HSEL = 0, HWRITE = 0, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR = 0, HWDATA = 0, HRDATA;
    logic [1:0] HTRANS = 0;
    logic [2:0] HSIZE = 0, HBURST = 0;
    logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [IDW-1:0] AWID, BID, ARID, RID;
    logic [3:0] AWLEN, WSTRB, ARLEN;
    logic [2:0] AWSIZE, ARSIZE;
    logic [1:0] AWBURST, BRESP, ARBURST, RRESP;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahbl_to_axi_bridge #(.ID_WIDTH(IDW), .AXI_ID(AXI_ID)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
        .WSTRB(WSTRB), .WLAST(WLAST), .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST), .RID(RID)
    );

    typedef struct {
        logic wr; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata;
        int awd, wd, bd, ard, rd; logic [1:0] bresp, rresp; logic [31:0] rdata;
    } xfer_t;
    typedef struct {
        int lat; logic resp, resp_prev; logic [31:0] hrdata;
        int aw_n, w_n, ar_n, aw_hi, w_hi, ar_hi;
        logic [31:0] addr; logic [2:0] size; logic [3:0] len; logic [1:0] burst; logic [IDW-1:0] id;
        logic [31:0] wdata; logic [3:0] wstrb; logic wlast;
    } obs_t;

    xfer_t seq[$];
    obs_t obs[$];
    logic [31:0] exp_hr[$];
    logic [31:0] hr_model = 0;
    int checks = 0, failures = 0;

    int awd_c = 0, wd_c = 0, bd_c = 0, ard_c = 0, rd_c = 0;
    logic [1:0] bresp_c = 0, rresp_c = 0;
    logic [31:0] rdata_c = 0;
    int aw_n = 0, w_n = 0, ar_n = 0, aw_hi = 0, w_hi = 0, ar_hi = 0;
    int awc = 0, wc = 0, bc = 0, arc = 0, rc = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [2:0] cap_size;
    logic [3:0] cap_len, cap_wstrb;
    logic [1:0] cap_burst;
    logic [IDW-1:0] cap_id;
    logic cap_wlast;
    logic [45:0] aw_prev, ar_prev;
    logic [36:0] w_prev;
    logic awv_p = 0, wv_p = 0, arv_p = 0;

    // AXI slave: each ready/valid answers after its configured number of wait cycles
    initial begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        BRESP = 0; RRESP = 0; RDATA = 0; RLAST = 0; BID = 0; RID = 0;
        forever begin
            @(negedge HCLK);
            if (AWVALID && awv_p) begin
                checks++;
                if ({AWADDR, AWSIZE, AWLEN, AWBURST, AWID} !== aw_prev) begin
                    failures++; $display("FAIL aw_stable got=%h exp=%h", {AWADDR, AWSIZE, AWLEN, AWBURST, AWID}, aw_prev);
                end
            end
            if (WVALID && wv_p) begin
                checks++;
                if ({WDATA, WSTRB, WLAST} !== w_prev) begin
                    failures++; $display("FAIL w_stable got=%h exp=%h", {WDATA, WSTRB, WLAST}, w_prev);
                end
            end
            if (ARVALID && arv_p) begin
                checks++;
                if ({ARADDR, ARSIZE, ARLEN, ARBURST, ARID} !== ar_prev) begin
                    failures++; $display("FAIL ar_stable got=%h exp=%h", {ARADDR, ARSIZE, ARLEN, ARBURST, ARID}, ar_prev);
                end
            end
            awv_p = AWVALID; wv_p = WVALID; arv_p = ARVALID;
            aw_prev = {AWADDR, AWSIZE, AWLEN, AWBURST, AWID};
            w_prev = {WDATA, WSTRB, WLAST};
            ar_prev = {ARADDR, ARSIZE, ARLEN, ARBURST, ARID};
            if (AWVALID) begin
                aw_hi++;
                if (awc == awd_c) begin
                    AWREADY = 1; aw_n++; awc = 0;
                    cap_addr = AWADDR; cap_size = AWSIZE; cap_len = AWLEN; cap_burst = AWBURST; cap_id = AWID;
                end else begin AWREADY = 0; awc++; end
            end else begin AWREADY = 0; awc = 0; end
            if (WVALID) begin
                w_hi++;
                if (wc == wd_c) begin
                    WREADY = 1; w_n++; wc = 0;
                    cap_wdata = WDATA; cap_wstrb = WSTRB; cap_wlast = WLAST;
                end else begin WREADY = 0; wc++; end
            end else begin WREADY = 0; wc = 0; end
            if (ARVALID) begin
                ar_hi++;
                if (arc == ard_c) begin
                    ARREADY = 1; ar_n++; arc = 0;
                    cap_addr = ARADDR; cap_size = ARSIZE; cap_len = ARLEN; cap_burst = ARBURST; cap_id = ARID;
                end else begin ARREADY = 0; arc++; end
            end else begin ARREADY = 0; arc = 0; end
            if (BREADY && bc == bd_c) begin BVALID = 1; BRESP = bresp_c; BID = IDW'($urandom); bc = 0; end
            else begin BVALID = 0; bc = BREADY ? bc + 1 : 0; end
            if (RREADY && rc == rd_c) begin
                RVALID = 1; RRESP = rresp_c; RDATA = rdata_c; RLAST = 1'($urandom); RID = IDW'($urandom); rc = 0;
            end else begin RVALID = 0; rc = RREADY ? rc + 1 : 0; end
        end
    end

    function automatic logic bad(input xfer_t x);
        return x.size > 3'd2 || (x.addr & ((32'd1 << x.size) - 32'd1)) != 0;
    endfunction

    function automatic int exp_lat(input xfer_t x);
        if (bad(x)) return 2;
        if (x.wr) return 3 + (x.awd > x.wd ? x.awd : x.wd) + x.bd + (x.bresp[1] ? 2 : 1);
        return 2 + x.ard + x.rd + (x.rresp[1] ? 2 : 1);
    endfunction

    function automatic logic [3:0] exp_strb(input xfer_t x);
        int nb;
        nb = 1 << x.size;
        return 4'(((1 << nb) - 1) << (x.addr % 4));
    endfunction

    function automatic xfer_t mk(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        xfer_t x;
        x = '{default: 0};
        x.wr = wr; x.addr = a; x.size = sz; x.wdata = $urandom; x.rdata = $urandom;
        return x;
    endfunction

    // drives seq[] as a pipelined AHB sequence, recording what each data phase looked like
    task automatic run_seq(input logic [2:0] burst);
        obs.delete(); exp_hr.delete();
        @(negedge HCLK);
        for (int i = 0; i < seq.size(); i++) begin
            obs_t o;
            xfer_t x;
            x = seq[i];
            o = '{default: 0};
            awd_c = x.awd; wd_c = x.wd; bd_c = x.bd; ard_c = x.ard; rd_c = x.rd;
            bresp_c = x.bresp; rresp_c = x.rresp; rdata_c = x.rdata;
            aw_n = 0; w_n = 0; ar_n = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
            HSEL = 1; HTRANS = i == 0 ? 2'b10 : 2'b11; HADDR = x.addr; HWRITE = x.wr; HSIZE = x.size; HBURST = burst;
            @(negedge HCLK);
            HTRANS = 2'b00; HWDATA = x.wdata;
            o.lat = 1;
            while (!HREADYOUT && o.lat < 100) begin
                o.resp_prev = HRESP; @(negedge HCLK); o.lat++;
            end
            o.resp = HRESP; o.hrdata = HRDATA;
            o.aw_n = aw_n; o.w_n = w_n; o.ar_n = ar_n; o.aw_hi = aw_hi; o.w_hi = w_hi; o.ar_hi = ar_hi;
            o.addr = cap_addr; o.size = cap_size; o.len = cap_len; o.burst = cap_burst; o.id = cap_id;
            o.wdata = cap_wdata; o.wstrb = cap_wstrb; o.wlast = cap_wlast;
            obs.push_back(o);
            if (!bad(x) && !x.wr) hr_model = x.rdata;
            exp_hr.push_back(hr_model);
        end
        HSEL = 0; HTRANS = 2'b00;
    endtask

    task automatic test_reset();
        HRESET = 1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        checks++;
        if ({HREADYOUT, HRESP, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 7'b1000000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=1000000", {HREADYOUT, HRESP, AWVALID, WVALID, BREADY, ARVALID, RREADY});
        end
        checks++;
        if ({HRDATA, WDATA, WSTRB, AWADDR, ARADDR} !== '0) begin
            failures++; $display("FAIL reset_regs got=%h exp=0", {HRDATA, WDATA, WSTRB, AWADDR, ARADDR});
        end
        HRESET = 0;
        HSEL = 1; HTRANS = 2'b00; HADDR = 32'h40; HWRITE = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            checks++;
            if ({HREADYOUT, HRESP, AWVALID, WVALID, ARVALID} !== 5'b10000) begin
                failures++; $display("FAIL idle_okay[%0d] got=%b exp=10000", i, {HREADYOUT, HRESP, AWVALID, WVALID, ARVALID});
            end
            if (i == 2) begin HSEL = 0; HTRANS = 2'b10; end
        end
        HTRANS = 2'b00;
    endtask

    task automatic test_write();
        seq.delete();
        seq.push_back(mk(1, 32'h40, 3'd2));
        seq[0].wdata = 32'hDEADBEEF;
        seq.push_back(mk(1, 32'h43, 3'd0));
        seq.push_back(mk(1, 32'h42, 3'd1));
        run_seq(3'b000);
        checks++;
        if ({obs[0].addr, obs[0].wdata, obs[0].wstrb, obs[0].len, obs[0].burst, obs[0].wlast} !== {32'h40, 32'hDEADBEEF, 4'hF, 4'h0, 2'b01, 1'b1}) begin
            failures++; $display("FAIL word_write got=%h %h %h %h", obs[0].addr, obs[0].wdata, obs[0].wstrb, obs[0].len);
        end
        checks++;
        if (obs[0].lat != 4 || obs[0].resp !== 1'b0) begin
            failures++; $display("FAIL word_write_lat got=%0d/%b exp=4/0", obs[0].lat, obs[0].resp);
        end
        checks++;
        if ({obs[1].wstrb, obs[1].size} !== {4'b1000, 3'd0}) begin
            failures++; $display("FAIL byte_strb got=%b/%0d exp=1000/0", obs[1].wstrb, obs[1].size);
        end
        checks++;
        if ({obs[2].wstrb, obs[2].size} !== {4'b1100, 3'd1}) begin
            failures++; $display("FAIL half_strb got=%b/%0d exp=1100/1", obs[2].wstrb, obs[2].size);
        end
        checks++;
        if (obs[0].id !== IDW'(AXI_ID)) begin
            failures++; $display("FAIL awid got=%0d exp=%0d", obs[0].id, AXI_ID);
        end
    endtask

    task automatic test_read();
        seq.delete();
        seq.push_back(mk(0, 32'h100, 3'd2));
        seq[0].rdata = 32'h12345678; seq[0].rd = 5; seq[0].ard = 2;
        run_seq(3'b000);
        checks++;
        if (obs[0].hrdata !== 32'h12345678) begin
            failures++; $display("FAIL read_data got=%h exp=12345678", obs[0].hrdata);
        end
        checks++;
        if ({obs[0].addr, obs[0].len, obs[0].burst} !== {32'h100, 4'h0, 2'b01} || obs[0].ar_hi != 3) begin
            failures++; $display("FAIL read_ar got=%h/%0d/%0d exp=100/0/3", obs[0].addr, obs[0].len, obs[0].ar_hi);
        end
        checks++;
        if (obs[0].lat != 10) begin
            failures++; $display("FAIL read_lat got=%0d exp=10", obs[0].lat);
        end
    endtask

    task automatic test_write_skew();
        seq.delete();
        seq.push_back(mk(1, 32'h80, 3'd2));
        seq[0].awd = 3; seq[0].bresp = 2'b10;
        run_seq(3'b000);
        checks++;
        if (obs[0].w_hi != 1 || obs[0].aw_hi != 4) begin
            failures++; $display("FAIL skew_valids got=w%0d/aw%0d exp=w1/aw4", obs[0].w_hi, obs[0].aw_hi);
        end
        checks++;
        if ({obs[0].resp_prev, obs[0].resp} !== 2'b11 || obs[0].lat != 8) begin
            failures++; $display("FAIL skew_err got=%b%b/%0d exp=11/8", obs[0].resp_prev, obs[0].resp, obs[0].lat);
        end
    endtask

    task automatic test_misalign();
        seq.delete();
        seq.push_back(mk(1, 32'h2, 3'd2));
        seq.push_back(mk(0, 32'h2, 3'd2));
        seq.push_back(mk(0, 32'h41, 3'd1));
        seq.push_back(mk(1, 32'h40, 3'd3));
        run_seq(3'b000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i].lat != 2 || {obs[i].resp_prev, obs[i].resp} !== 2'b11) begin
                failures++; $display("FAIL misalign_resp[%0d] got=%0d/%b%b exp=2/11", i, obs[i].lat, obs[i].resp_prev, obs[i].resp);
            end
            checks++;
            if (obs[i].aw_hi + obs[i].w_hi + obs[i].ar_hi != 0) begin
                failures++; $display("FAIL misalign_axi[%0d] got=%0d exp=0", i, obs[i].aw_hi + obs[i].w_hi + obs[i].ar_hi);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFF0;
        seq.delete();
        for (int i = 0; i < 4; i++) seq.push_back(mk(0, base + 32'(4 * i), 3'd2));
        run_seq(3'b011);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i].ar_n != 1 || obs[i].addr !== base + 32'(4 * i) || obs[i].len !== 4'h0) begin
                failures++; $display("FAIL incr4_ar[%0d] got=%0d/%h/%0d exp=1/%h/0", i, obs[i].ar_n, obs[i].addr, obs[i].len, base + 32'(4 * i));
            end
            checks++;
            if (obs[i].lat != 3 || obs[i].hrdata !== seq[i].rdata) begin
                failures++; $display("FAIL incr4_data[%0d] got=%0d/%h exp=3/%h", i, obs[i].lat, obs[i].hrdata, seq[i].rdata);
            end
        end
    endtask

    task automatic test_random();
        for (int g = 0; g < 12; g++) begin
            seq.delete();
            for (int k = 0; k < $urandom_range(1, 6); k++) begin
                xfer_t x;
                logic [2:0] sz;
                logic [31:0] a;
                sz = $urandom_range(0, 15) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                a = $urandom;
                if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                x = mk(1'($urandom), a, sz);
                x.awd = $urandom_range(0, 3); x.wd = $urandom_range(0, 3); x.bd = $urandom_range(0, 3);
                x.ard = $urandom_range(0, 3); x.rd = $urandom_range(0, 3);
                x.bresp = {$urandom_range(0, 4) == 0, 1'($urandom)};
                x.rresp = {$urandom_range(0, 4) == 0, 1'($urandom)};
                seq.push_back(x);
            end
            run_seq(3'($urandom));
            for (int i = 0; i < obs.size(); i++) begin
                xfer_t x;
                obs_t o;
                logic e, err;
                x = seq[i]; o = obs[i]; e = bad(x);
                err = e | (x.wr ? x.bresp[1] : x.rresp[1]);
                checks++;
                if (o.lat != exp_lat(x)) begin
                    failures++; $display("FAIL rnd_lat[%0d.%0d] got=%0d exp=%0d", g, i, o.lat, exp_lat(x));
                end
                checks++;
                if ({o.resp_prev, o.resp} !== {err, err}) begin
                    failures++; $display("FAIL rnd_resp[%0d.%0d] got=%b%b exp=%b%b", g, i, o.resp_prev, o.resp, err, err);
                end
                checks++;
                if (o.hrdata !== exp_hr[i]) begin
                    failures++; $display("FAIL rnd_hrdata[%0d.%0d] got=%h exp=%h", g, i, o.hrdata, exp_hr[i]);
                end
                checks++;
                if (o.aw_n != int'(!e && x.wr) || o.w_n != int'(!e && x.wr) || o.ar_n != int'(!e && !x.wr)) begin
                    failures++; $display("FAIL rnd_count[%0d.%0d] got=%0d%0d%0d", g, i, o.aw_n, o.w_n, o.ar_n);
                end
                if (!e) begin
                    checks++;
                    if ({o.addr, o.size, o.len, o.burst, o.id} !== {x.addr, x.size, 4'h0, 2'b01, IDW'(AXI_ID)}) begin
                        failures++; $display("FAIL rnd_ax[%0d.%0d] got=%h/%0d exp=%h/%0d", g, i, o.addr, o.size, x.addr, x.size);
                    end
                end
                if (!e && x.wr) begin
                    checks++;
                    if ({o.wdata, o.wstrb, o.wlast} !== {x.wdata, exp_strb(x), 1'b1}) begin
                        failures++; $display("FAIL rnd_w[%0d.%0d] got=%h/%b exp=%h/%b", g, i, o.wdata, o.wstrb, x.wdata, exp_strb(x));
                    end
                    checks++;
                    if (o.aw_hi != x.awd + 1 || o.w_hi != x.wd + 1) begin
                        failures++; $display("FAIL rnd_valids[%0d.%0d] got=aw%0d/w%0d exp=aw%0d/w%0d", g, i, o.aw_hi, o.w_hi, x.awd + 1, x.wd + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        awd_c = 10; wd_c = 0;
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HADDR = 32'h80; HWRITE = 1; HSIZE = 3'd2;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HWDATA = $urandom;
        n = 0;
        while (!AWVALID && n < 10) begin @(negedge HCLK); n++; end
        checks++;
        if (AWVALID !== 1'b1) begin
            failures++; $display("FAIL mid_awvalid got=%b exp=1", AWVALID);
        end
        HRESET = 1;
        @(negedge HCLK);
        checks++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, HREADYOUT, HRESP} !== 7'b0000010) begin
            failures++; $display("FAIL mid_reset got=%b exp=0000010", {AWVALID, WVALID, ARVALID, BREADY, RREADY, HREADYOUT, HRESP});
        end
        HRESET = 0;
        hr_model = 0;
        seq.delete();
        seq.push_back(mk(0, 32'h300, 3'd2));
        run_seq(3'b000);
        checks++;
        if (obs[0].lat != 3 || obs[0].hrdata !== seq[0].rdata || obs[0].resp !== 1'b0) begin
            failures++; $display("FAIL post_reset_read got=%0d/%h exp=3/%h", obs[0].lat, obs[0].hrdata, seq[0].rdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_write_skew();
        test_misalign();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
